// File: rtl/gpio_dbus_arbiter.sv
// Round-robin arbiter sharing the GPIO peripheral dbus port between the core (m0)
// and the debug/DMA master (m1), with a watchdog on unanswered transactions.
module gpio_dbus_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        m0_req_i,
  input  logic        m0_w_en_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_w_data_i,
  output logic [31:0] m0_r_data_o,
  output logic        m0_ack_o,

  input  logic        m1_req_i,
  input  logic        m1_w_en_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_w_data_i,
  output logic [31:0] m1_r_data_o,
  output logic        m1_ack_o,

  output logic        per_req_o,
  output logic        per_w_en_o,
  output logic [31:0] per_addr_o,
  output logic [31:0] per_w_data_o,
  input  logic [31:0] per_r_data_i,
  input  logic        per_ack_i,

  output logic        timeout_o,
  output logic        grant_o
);

  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DATA_W = 32;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              ptr, ptr_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              per_req_nxt;
  logic              per_w_en_nxt;
  logic [DATA_W-1:0] per_addr_nxt;
  logic [DATA_W-1:0] per_w_data_nxt;
  logic              m0_ack_nxt, m1_ack_nxt;
  logic [DATA_W-1:0] m0_r_data_nxt, m1_r_data_nxt;
  logic              timeout_nxt;
  logic              grant_nxt;
  logic              elig0, elig1, sel;

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= 1'b0;
      cnt          <= '0;
      per_req_o    <= 1'b0;
      per_w_en_o   <= 1'b0;
      per_addr_o   <= '0;
      per_w_data_o <= '0;
      m0_ack_o     <= 1'b0;
      m1_ack_o     <= 1'b0;
      m0_r_data_o  <= '0;
      m1_r_data_o  <= '0;
      timeout_o    <= 1'b0;
      grant_o      <= 1'b0;
    end else begin
      state        <= state_nxt;
      ptr          <= ptr_nxt;
      cnt          <= cnt_nxt;
      per_req_o    <= per_req_nxt;
      per_w_en_o   <= per_w_en_nxt;
      per_addr_o   <= per_addr_nxt;
      per_w_data_o <= per_w_data_nxt;
      m0_ack_o     <= m0_ack_nxt;
      m1_ack_o     <= m1_ack_nxt;
      m0_r_data_o  <= m0_r_data_nxt;
      m1_r_data_o  <= m1_r_data_nxt;
      timeout_o    <= timeout_nxt;
      grant_o      <= grant_nxt;
    end
  end

  // Next-state and next-output logic; ack/timeout are single-cycle pulses
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    cnt_nxt        = cnt;
    per_req_nxt    = per_req_o;
    per_w_en_nxt   = per_w_en_o;
    per_addr_nxt   = per_addr_o;
    per_w_data_nxt = per_w_data_o;
    m0_ack_nxt     = 1'b0;
    m1_ack_nxt     = 1'b0;
    m0_r_data_nxt  = m0_r_data_o;
    m1_r_data_nxt  = m1_r_data_o;
    timeout_nxt    = 1'b0;
    grant_nxt      = grant_o;
    elig0          = m0_req_i & ~m0_ack_o;
    elig1          = m1_req_i & ~m1_ack_o;
    sel            = 1'b0;

    case (state)
      IDLE: begin
        if (elig0 | elig1) begin
          sel            = (elig0 & elig1) ? ptr : elig1;
          per_w_en_nxt   = sel ? m1_w_en_i   : m0_w_en_i;
          per_addr_nxt   = sel ? m1_addr_i   : m0_addr_i;
          per_w_data_nxt = sel ? m1_w_data_i : m0_w_data_i;
          per_req_nxt    = 1'b1;
          grant_nxt      = sel;
          cnt_nxt        = '0;
          state_nxt      = BUSY;
        end
      end

      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        // A real ack takes precedence over the watchdog in the limit cycle
        if (per_ack_i || (cnt == CNT_LAST)) begin
          per_req_nxt = 1'b0;
          timeout_nxt = ~per_ack_i;
          state_nxt   = RESP;
          if (grant_o) begin
            m1_ack_nxt    = 1'b1;
            m1_r_data_nxt = per_ack_i ? per_r_data_i : ERR_RDATA;
          end else begin
            m0_ack_nxt    = 1'b1;
            m0_r_data_nxt = per_ack_i ? per_r_data_i : ERR_RDATA;
          end
        end
      end

      RESP: begin
        ptr_nxt   = ~grant_o;
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_gpio_dbus_arbiter.sv
// Bench for gpio_dbus_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level round-robin model driving a simple peripheral.
module tb_gpio_dbus_arbiter;

  localparam int unsigned TO_CYC = 16;
  localparam logic [31:0] ERR    = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [1:0]  m_req;
  logic [1:0]  m_wen;
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        per_req, per_w_en;
  logic [31:0] per_addr, per_w_data;
  logic [31:0] per_rdata;
  logic        per_ack;
  logic        timeout, grant;

  int          n_cmp;
  int          n_err;
  int          ptr;
  logic [31:0] mdl_rd [2];
  int          w;

  gpio_dbus_arbiter #(.TIMEOUT_CYC(TO_CYC), .ERR_RDATA(ERR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m0_req_i     (m_req[0]),
    .m0_w_en_i    (m_wen[0]),
    .m0_addr_i    (m_addr[0]),
    .m0_w_data_i  (m_wdata[0]),
    .m0_r_data_o  (m0_rdata),
    .m0_ack_o     (m0_ack),
    .m1_req_i     (m_req[1]),
    .m1_w_en_i    (m_wen[1]),
    .m1_addr_i    (m_addr[1]),
    .m1_w_data_i  (m_wdata[1]),
    .m1_r_data_o  (m1_rdata),
    .m1_ack_o     (m1_ack),
    .per_req_o    (per_req),
    .per_w_en_o   (per_w_en),
    .per_addr_o   (per_addr),
    .per_w_data_o (per_w_data),
    .per_r_data_i (per_rdata),
    .per_ack_i    (per_ack),
    .timeout_o    (timeout),
    .grant_o      (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic ack_of(input int i);
    return (i == 1) ? m1_ack : m0_ack;
  endfunction

  function automatic logic [31:0] rd_of(input int i);
    return (i == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic check_all_zero(input string tag);
    check_bit({tag, "_per_req"}, per_req, 1'b0);
    check_bit({tag, "_per_w_en"}, per_w_en, 1'b0);
    check({tag, "_per_addr"}, per_addr, 32'h0);
    check({tag, "_per_w_data"}, per_w_data, 32'h0);
    check_bit({tag, "_m0_ack"}, m0_ack, 1'b0);
    check_bit({tag, "_m1_ack"}, m1_ack, 1'b0);
    check({tag, "_m0_rdata"}, m0_rdata, 32'h0);
    check({tag, "_m1_rdata"}, m1_rdata, 32'h0);
    check_bit({tag, "_timeout"}, timeout, 1'b0);
    check_bit({tag, "_grant"}, grant, 1'b0);
  endtask

  // Entered at a negedge in IDLE with requests set; returns at the negedge of the
  // IDLE cycle after the master ack. lat = BUSY cycle index of the peripheral ack.
  task automatic serve_one(input int lat, input logic [31:0] pdata, input bit rearm,
                           input bit drop_early, input bit spurious, output int winner);
    int          other;
    logic        exp_wen;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    bit          acked;
    if (m_req == 2'b11) winner = ptr;
    else                winner = m_req[1] ? 1 : 0;
    other     = 1 - winner;
    exp_wen   = m_wen[winner];
    exp_addr  = m_addr[winner];
    exp_wdata = m_wdata[winner];
    acked     = 1'b0;
    @(negedge clk);
    check_bit("grant", grant, 1'(winner));
    check_bit("per_w_en", per_w_en, exp_wen);
    check("per_w_data", per_w_data, exp_wdata);
    for (int idx = 0; idx < int'(TO_CYC); idx++) begin
      check_bit("per_req_busy", per_req, 1'b1);
      check("per_addr", per_addr, exp_addr);
      check_bit("ack_in_busy", m0_ack | m1_ack, 1'b0);
      if (drop_early && idx == 0) m_req[winner] = 1'b0;
      if (m_req[other] == 1'b0) begin
        m_addr[other]  = $urandom;
        m_wdata[other] = $urandom;
      end
      if (idx == lat) begin
        per_ack   = 1'b1;
        per_rdata = pdata;
        @(negedge clk);
        per_ack   = 1'b0;
        per_rdata = $urandom;
        acked     = 1'b1;
        break;
      end
      per_rdata = $urandom;
      @(negedge clk);
    end
    exp_rd = acked ? pdata : ERR;
    check_bit("per_req_resp", per_req, 1'b0);
    check_bit("ack_winner", ack_of(winner), 1'b1);
    check_bit("ack_other", ack_of(other), 1'b0);
    check("rdata_winner", rd_of(winner), exp_rd);
    check("rdata_other_hold", rd_of(other), mdl_rd[other]);
    check_bit("timeout_resp", timeout, !acked);
    mdl_rd[winner] = exp_rd;
    ptr = other;
    if (!rearm) m_req[winner] = 1'b0;
    if (spurious) per_ack = 1'b1;
    @(negedge clk);
    per_ack = 1'b0;
    check_bit("per_req_gap", per_req, 1'b0);
    check_bit("ack_idle", m0_ack | m1_ack, 1'b0);
    check_bit("timeout_idle", timeout, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ptr = 0;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
  endtask

  task automatic set_req(input int i, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
    m_req[i]   = 1'b1;
    m_wen[i]   = wen;
    m_addr[i]  = addr;
    m_wdata[i] = wdata;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    ptr = 0;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    rst_n = 1'b0;
    m_req = 2'b00;
    m_wen = 2'b00;
    m_addr[0] = 32'h0;  m_addr[1] = 32'h0;
    m_wdata[0] = 32'h0; m_wdata[1] = 32'h0;
    per_ack = 1'b0;
    per_rdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Single read from m0 at 0x04, peripheral acks one cycle after request
    set_req(0, 1'b0, 32'h0000_0004, 32'h0);
    serve_one(1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, w);
    check("single_read_winner", 32'(w), 32'd0);

    // Simultaneous requests right after reset: m0 first, then m1
    do_reset();
    set_req(0, 1'b1, 32'h0000_0010, 32'h0000_1234);
    set_req(1, 1'b0, 32'h0000_0020, 32'h0);
    serve_one(2, 32'h1111_0000, 1'b0, 1'b0, 1'b0, w);
    check("simul_first", 32'(w), 32'd0);
    serve_one(1, 32'h2222_0000, 1'b0, 1'b0, 1'b0, w);
    check("simul_second", 32'(w), 32'd1);

    // Fairness: both masters keep requesting for six transactions
    set_req(0, 1'b0, 32'h0000_0008, 32'h0);
    set_req(1, 1'b1, 32'h0000_000C, 32'hCAFE_0001);
    for (int k = 0; k < 6; k++) begin
      serve_one(1 + k, $urandom, 1'b1, 1'b0, 1'b0, w);
      check("fair_alternate", 32'(w), 32'(k % 2));
    end
    m_req = 2'b00;
    @(negedge clk);

    // Timeout: move the pointer to m1, then m1 read never acked while m0 waits
    set_req(0, 1'b0, 32'h0000_0004, 32'h0);
    serve_one(1, 32'h0000_0001, 1'b0, 1'b0, 1'b0, w);
    set_req(0, 1'b0, 32'h0000_0014, 32'h0);
    set_req(1, 1'b0, 32'h0000_0018, 32'h0);
    serve_one(99, 32'h0, 1'b0, 1'b0, 1'b0, w);
    check("timeout_winner", 32'(w), 32'd1);
    check("timeout_m1_data", m1_rdata, 32'hDEAD_BEEF);
    serve_one(3, 32'h0000_0077, 1'b0, 1'b0, 1'b0, w);
    check("after_timeout_winner", 32'(w), 32'd0);

    // Ack arriving in the watchdog limit cycle wins
    set_req(0, 1'b0, 32'h0000_0024, 32'h0);
    serve_one(int'(TO_CYC) - 1, 32'h0000_0055, 1'b0, 1'b0, 1'b0, w);
    check("collision_m0_data", m0_rdata, 32'h0000_0055);

    // Reset while BUSY, then both requesting: m0 first
    set_req(1, 1'b0, 32'h0000_0030, 32'h0);
    serve_one(1, 32'h0000_0003, 1'b0, 1'b0, 1'b0, w);
    set_req(0, 1'b1, 32'h0000_0040, 32'hA0A0_0000);
    set_req(1, 1'b0, 32'h0000_0044, 32'h0);
    @(negedge clk);
    check_bit("midbusy_per_req", per_req, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("midbusy_reset");
    rst_n = 1'b1;
    ptr = 0;
    mdl_rd[0] = 32'h0;
    mdl_rd[1] = 32'h0;
    serve_one(2, 32'h0000_00E0, 1'b0, 1'b0, 1'b0, w);
    check("post_reset_first", 32'(w), 32'd0);
    serve_one(2, 32'h0000_00E1, 1'b0, 1'b0, 1'b0, w);
    check("post_reset_second", 32'(w), 32'd1);

    // Randomized traffic against the round-robin model
    for (int it = 0; it < 30; it++) begin
      int pat;
      int guard;
      pat = int'($urandom_range(1, 3));
      for (int i = 0; i < 2; i++) begin
        if (pat[i]) set_req(i, 1'($urandom % 2), $urandom, $urandom);
      end
      guard = 0;
      while (m_req != 2'b00 && guard < 4) begin
        serve_one(int'($urandom_range(1, 19)), $urandom, 1'b0,
                  ($urandom % 8) == 0, 1'($urandom % 2), w);
        guard++;
      end
      check("rand_drained", 32'(m_req), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_dbus_arbiter.md
Name: gpio_dbus_arbiter

Overview:
Two-master arbiter sharing the single dbus slave port of the special GPIO peripheral (switch/LED registers) between the core data bus (m0) and the debug/DMA master (m1).
- Grants one transaction at a time with round-robin fairness.
- Latches the winner's request and drives it to the peripheral until the peripheral acks.
- Returns the ack and read data to the winning master only.
- A watchdog terminates transactions the peripheral never acks, so no master hangs.

Parameters:
TIMEOUT_CYC, 16, max cycles in BUSY awaiting per_ack_i before forced completion (legal range 2..255)
ERR_RDATA, 32'hDEAD_BEEF, read data returned on a timed-out transaction

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
m0_req_i  input  1  master 0 request; held until m0_ack_o
m0_w_en_i  input  1  master 0 write enable (1 write, 0 read)
m0_addr_i  input  32  master 0 address
m0_w_data_i  input  32  master 0 write data
m0_r_data_o  output  32  master 0 read data, valid with m0_ack_o
m0_ack_o  output  1  master 0 completion pulse
m1_req_i, m1_w_en_i, m1_addr_i, m1_w_data_i, m1_r_data_o, m1_ack_o: same as m0, for master 1
per_req_o  output  1  request to peripheral
per_w_en_o  output  1  latched write enable
per_addr_o  output  32  latched address
per_w_data_o  output  32  latched write data
per_r_data_i  input  32  peripheral read data, valid with per_ack_i
per_ack_i  input  1  peripheral ack, one-cycle pulse
timeout_o  output  1  one-cycle pulse when a transaction is force-completed
grant_o  output  1  index of the current/last granted master

Behaviour:
- Reset: state IDLE. All outputs 0: per_*, m*_ack_o, m*_r_data_o, timeout_o, grant_o. Round-robin pointer = m0 (m0 has priority first). Timeout counter = 0.
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE:
  - Eligible request = mX_req_i & ~mX_ack_o. This masks a master whose ack pulse is high this cycle.
  - If both are eligible, grant the pointer's master. If only one is eligible, grant it.
  - On grant: latch that master's w_en/addr/w_data into per_*, set per_req_o=1, set grant_o, clear the counter, go to BUSY.
- BUSY:
  - per_req_o held at 1; per_* stable; master-side inputs ignored.
  - Counter increments each cycle.
  - per_ack_i=1: capture per_r_data_i (writes capture it as well, value is don't-care), drop per_req_o next cycle, go to RESP.
  - Else if counter == TIMEOUT_CYC-1: capture ERR_RDATA, pulse timeout_o, drop per_req_o, go to RESP.
  - If per_ack_i arrives in the same cycle the counter hits the limit, the ack wins and timeout_o stays 0.
- RESP (exactly one cycle):
  - Granted master gets mX_ack_o=1 and mX_r_data_o = captured data. The other master's ack stays 0.
  - Pointer moves to the non-granted master. Go to IDLE.
- The non-granted master's r_data_o holds its previous value.
- Timing:
  - Minimum transaction: request seen in IDLE cycle t, per_req_o high at t+1, ack no earlier than t+2, mX_ack_o at t+3 (for a peripheral acking one cycle after request).
  - Back-to-back throughput: one transaction per 3 cycles + peripheral latency.
- Peripheral must see per_req_o low for at least one cycle between transactions (guaranteed by RESP/IDLE).
- Spurious per_ack_i in IDLE or RESP is ignored.
- Reset asserted mid-BUSY: per_req_o drops the next cycle, no master ack is issued, pointer returns to m0.
- Master dropping req mid-transaction is illegal. The arbiter completes the transaction anyway and acks.

Test Plan:
- Single read: m0 reads addr 0x04; peripheral acks 1 cycle after per_req_o with 0x0000_00A5 -> per_addr_o=0x04, per_w_en_o=0, m0_ack_o one pulse with m0_r_data_o=0x0000_00A5, m1_ack_o stays 0.
- Simultaneous requests after reset: m0 writes 0x1234 and m1 reads, both held -> m0 served first, then m1; grant_o goes 0 then 1; exactly one ack pulse per master; per_req_o low ≥1 cycle between transactions.
- Fairness: both masters request continuously for 6 transactions -> grants alternate m0,m1,m0,m1,m0,m1.
- Timeout: m1 reads, peripheral never acks, TIMEOUT_CYC=16 -> per_req_o high for 16 cycles, timeout_o pulses once, m1_ack_o with m1_r_data_o=0xDEAD_BEEF, arbiter then serves a pending m0 normally.
- Ack/timeout collision: per_ack_i arrives exactly in the limit cycle with data 0x55 -> timeout_o=0, master receives 0x55.
- Reset mid-BUSY: rst_n low while per_req_o=1 -> next cycle all outputs 0, no ack issued; after release with both requesting, m0 is granted first.
